// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Brief    : Iterative radix-2 shift-and-add multiplier, one bit per cycle,
//            valid/ready on operands and product. Define MULT_SIGNED_EN for
//            two's-complement operands and a signed product.
// Revision : 1.0
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes are taken as unsigned WIDTH-bit values, so the most negative
  // operand maps cleanly to 2^(WIDTH-1).
  assign op_a   = a[WIDTH-1] ? -a : a;
  assign op_b   = b[WIDTH-1] ? -b : b;
  assign result = neg_q ? -acc_sum : acc_sum;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign result = acc_sum;
`endif

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign busy      = (state_q == S_BUSY);
  assign out_valid = out_valid_q;
  assign p         = p_q;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
`ifdef MULT_SIGNED_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = S_BUSY;
          mcand_d  = {{WIDTH{1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == C_LAST) begin
          p_d         = result;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
`ifdef MULT_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Directed self-checking bench for seq_multiplier with a product
//            scoreboard; signed cases enabled by MULT_SIGNED_EN.
// Revision : 1.0
// ============================================================================
module tb_seq_multiplier;

  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a, b;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] p;
  logic              busy;

  logic [2*WIDTH-1:0] sb[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MULT_SIGNED_EN
    logic signed [2*WIDTH-1:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    return {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // transfer edge, where the block is idle again.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input int stall, input bit hold);
    logic [2*WIDTH-1:0] exp;
    int cycles;
    int busy_cnt;
    a         = ta;
    b         = tb_v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    check("in_ready_at_accept", in_ready, 1);
    sb.push_back(model(ta, tb_v));
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    a = ~ta;
    b = tb_v + 8'd1;
    cycles   = 0;
    busy_cnt = 0;
    while (!out_valid && cycles < 4 * WIDTH) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    check("latency", cycles, WIDTH);
    check("busy_cycles", busy_cnt, WIDTH);
    check("busy_in_done", busy, 0);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'h33;
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        if (sb.size() != 0) check("stall_p", p, sb[0]);
        @(negedge clk);
      end
      in_valid  = hold;
      out_ready = 1'b1;
    end
    check("out_valid", out_valid, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      exp = '0;
    end else begin
      exp = sb.pop_front();
      check("product", p, exp);
    end
    @(negedge clk);
    check("out_valid_after_xfer", out_valid, 0);
    check("in_ready_after_xfer", in_ready, 1);
    check("p_held_after_xfer", p, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(negedge clk);

    run_op(8'd12, 8'd10, 0, 1'b0);
    run_op(8'd255, 8'd255, 0, 1'b0);
    run_op(8'd0, 8'd200, 0, 1'b0);
    run_op(8'd13, 8'd11, 5, 1'b0);
    run_op(8'd3, 8'd7, 0, 1'b1);
    run_op(8'd9, 8'd9, 0, 1'b0);

    // Abort an operation part-way through with reset.
    a = 8'd100;
    b = 8'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_p", p, 0);
    check("abort_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_abort", in_ready, 1);
    check("no_product_after_abort", out_valid, 0);
    run_op(8'd6, 8'd7, 0, 1'b0);

`ifdef MULT_SIGNED_EN
    run_op(8'hFD, 8'd5, 0, 1'b0);
    run_op(8'h80, 8'h80, 0, 1'b0);
    run_op(8'h80, 8'd1, 0, 1'b0);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
